spi_os_receiver: RTL and testbench

SPI_OS_RECEIVER -- requirements
Module: spi_os_receiver

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_rx_fifo.sv | 81 ++++++++
 rtl/spi_os_receiver.sv | 184 ++++++++++++++++++
 tb/tb_spi_os_receiver.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default word width,
// common to the SPI master, slave and oversampled receiver.
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int SPI_WIDTH = 8;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO with registered head word, level and
// flags; a write to a full FIFO is accepted only if a pop frees a slot that cycle.
module spi_rx_fifo import spi_pkg::*; #(
  parameter int WIDTH = SPI_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   i_areset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [WIDTH-1:0] head_r;
  logic             empty_r;
  logic             full_r;
  logic [LW-1:0]    level_r;

  logic             pop_s;
  logic             wr_accept_s;
  logic [AW-1:0]    rd_ptr_next_s;
  logic [LW-1:0]    level_next_s;

  assign rd_data = head_r;
  assign empty   = empty_r;
  assign full    = full_r;
  assign level   = level_r;

  // Next-state decode for read pointer and occupancy
  always_comb begin
    pop_s       = rd_en & ~empty_r;
    wr_accept_s = wr_en & (~full_r | pop_s);
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    level_next_s = level_r + LW'(wr_accept_s) - LW'(pop_s);
  end

  // Storage, pointers and the head register that precomputes the next word out
  always_ff @(posedge clk or posedge i_areset) begin
    if (i_areset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      head_r   <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      level_r  <= '0;
    end else begin
      if (wr_accept_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_next_s;
      // The incoming word becomes the head when it lands in the next read slot
      if (wr_accept_s && (rd_ptr_next_s == wr_ptr_r)) begin
        head_r <= wr_data;
      end else begin
        head_r <= mem_r[rd_ptr_next_s];
      end
      level_r <= level_next_s;
      empty_r <= (level_next_s == '0);
      full_r  <= (level_next_s == LW'(DEPTH));
    end
  end

endmodule

// File: rtl/spi_os_receiver.sv
// Oversampled CPOL-0 SPI receiver: synchronizes sclk/mosi/cs into clk, shifts
// words MSB first into a FWFT FIFO. Define SPI_RX_OVF_CNT_EN to add o_ovf_count.
module spi_os_receiver import spi_pkg::*; #(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   i_areset,
  input  logic                   i_sclk,
  input  logic                   i_mosi,
  input  logic                   i_cs,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow,
  input  logic                   i_clear,
  output logic                   o_desync,
  output logic                   o_busy
`ifdef SPI_RX_OVF_CNT_EN
  ,
  output logic [7:0]             o_ovf_count
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sclk_prev_r;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   rise_s;

  spi_state_e             state_r;
  logic [WIDTH-1:0]       shift_r;
  logic [CW-1:0]          bit_cnt_r;
  logic                   wr_en_r;
  logic [WIDTH-1:0]       wr_data_r;
  logic                   desync_r;
  logic                   busy_r;
  logic                   ovf_r;
  logic                   drop_s;

  logic [WIDTH-1:0]       fifo_data_s;
  logic                   fifo_empty_s;
  logic                   fifo_full_s;
  logic [LW-1:0]          fifo_level_s;

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];
  assign rise_s = sclk_s & ~sclk_prev_r;

  // A completed word is lost only when the FIFO is full and nobody pops it this cycle
  assign drop_s = wr_en_r & fifo_full_s & ~(i_ready & ~fifo_empty_s);

  assign o_data     = fifo_data_s;
  assign o_valid    = ~fifo_empty_s;
  assign o_level    = fifo_level_s;
  assign o_overflow = ovf_r;
  assign o_desync   = desync_r;
  assign o_busy     = busy_r;

  // Synchronizer chains and sclk edge-detect history
  always_ff @(posedge clk or posedge i_areset) begin
    if (i_areset) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      cs_sync_r   <= '0;
      sclk_prev_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], i_sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], i_cs};
      sclk_prev_r <= sclk_s;
    end
  end

  // Frame FSM: shift on sclk rising edges, hand complete words to the FIFO
  always_ff @(posedge clk or posedge i_areset) begin
    if (i_areset) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      wr_en_r   <= 1'b0;
      wr_data_r <= '0;
      desync_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      wr_en_r  <= 1'b0;
      desync_r <= 1'b0;
      case (state_r)
        IDLE: begin
          bit_cnt_r <= '0;
          if (cs_s) begin
            state_r <= SHIFT;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SHIFT: begin
          if (!cs_s) begin
            // Frame closed mid-word: flag it and throw the partial bits away
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            desync_r  <= (bit_cnt_r != '0);
            bit_cnt_r <= '0;
          end else if (rise_s) begin
            shift_r <= {shift_r[WIDTH-2:0], mosi_s};
            if (bit_cnt_r == CW'(WIDTH - 1)) begin
              wr_en_r   <= 1'b1;
              wr_data_r <= {shift_r[WIDTH-2:0], mosi_s};
              bit_cnt_r <= '0;
            end else begin
              bit_cnt_r <= bit_cnt_r + CW'(1);
            end
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          bit_cnt_r <= '0;
        end
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a coincident clear
  always_ff @(posedge clk or posedge i_areset) begin
    if (i_areset) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (i_clear) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

`ifdef SPI_RX_OVF_CNT_EN
  logic [7:0] ovf_cnt_r;

  assign o_ovf_count = ovf_cnt_r;

  // Saturating count of dropped words
  always_ff @(posedge clk or posedge i_areset) begin
    if (i_areset) begin
      ovf_cnt_r <= 8'd0;
    end else if (i_clear) begin
      ovf_cnt_r <= drop_s ? 8'd1 : 8'd0;
    end else if (drop_s && (ovf_cnt_r != 8'd255)) begin
      ovf_cnt_r <= ovf_cnt_r + 8'd1;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end
`endif

  spi_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .i_areset (i_areset),
    .wr_en    (wr_en_r),
    .wr_data  (wr_data_r),
    .rd_en    (i_ready),
    .rd_data  (fifo_data_s),
    .empty    (fifo_empty_s),
    .full     (fifo_full_s),
    .level    (fifo_level_s)
  );

endmodule

// File: tb/tb_spi_os_receiver.sv
// Self-checking bench for spi_os_receiver: scoreboard of expected words popped
// by a consumer monitor, plus per-scenario flag, level and latency checks.
`timescale 1ns/1ps
module tb_spi_os_receiver;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
  localparam int HALF  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             i_areset;
  logic             i_sclk;
  logic             i_mosi;
  logic             i_cs;
  logic             i_ready;
  logic             i_clear;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic [LW-1:0]    o_level;
  logic             o_overflow;
  logic             o_desync;
  logic             o_busy;
`ifdef SPI_RX_OVF_CNT_EN
  logic [7:0]       o_ovf_count;
`endif

  int               checks = 0;
  int               errors = 0;
  int               desync_seen = 0;
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_w;

  always #5 clk = ~clk;

  spi_os_receiver #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk         (clk),
    .i_areset    (i_areset),
    .i_sclk      (i_sclk),
    .i_mosi      (i_mosi),
    .i_cs        (i_cs),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_level     (o_level),
    .o_overflow  (o_overflow),
    .i_clear     (i_clear),
    .o_desync    (o_desync),
    .o_busy      (o_busy)
`ifdef SPI_RX_OVF_CNT_EN
    ,
    .o_ovf_count (o_ovf_count)
`endif
  );

  // Consumer side: every accepted pop must match the oldest expected word
  always @(negedge clk) begin
    if (o_desync === 1'b1) desync_seen++;
    if (i_areset === 1'b0 && o_valid === 1'b1 && i_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, expected no word", o_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (o_data !== exp_w) begin
          errors++;
          $display("FAIL pop_data: got %h, expected %h", o_data, exp_w);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    i_cs   = 1'b1;
    i_sclk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic end_frame;
    i_sclk = 1'b0;
    repeat (HALF) tick();
    i_cs = 1'b0;
    repeat (6) tick();
  endtask

  task automatic send_bit(input logic b, input bit last, input bit lat_chk, input bit rdy_pulse);
    logic exp_v;
    i_mosi = b;
    i_sclk = 1'b0;
    repeat (HALF) tick();
    i_sclk = 1'b1;
    for (int k = 0; k < HALF; k++) begin
      tick();
      if (last && lat_chk) begin
        exp_v = (k >= SYNC + 1) ? 1'b1 : 1'b0;
        checks++;
        if (o_valid !== exp_v) begin
          errors++;
          $display("FAIL latency_valid[%0d]: got %b, expected %b", k, o_valid, exp_v);
        end
      end
      if (last && rdy_pulse) begin
        if (k == SYNC) begin
          i_ready = 1'b1;
        end else if (k == SYNC + 1) begin
          i_ready = 1'b0;
          checks++;
          if (o_level !== LW'(DEPTH) || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_write: got level %0d ovf %b, expected level %0d ovf 0",
                     o_level, o_overflow, DEPTH);
          end
        end
      end
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit store, input bit lat_chk,
                           input bit rdy_pulse);
    if (store) exp_q.push_back(w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      send_bit(w[i], (i == 0), lat_chk, rdy_pulse);
    end
  endtask

  task automatic drain;
    i_ready = 1'b1;
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) tick();
    tick();
    i_ready = 1'b0;
    tick();
    checks++;
    if (exp_q.size() != 0 || o_valid !== 1'b0 || o_level !== '0) begin
      errors++;
      $display("FAIL drain: got %0d words pending, valid %b, level %0d, expected 0/0/0",
               exp_q.size(), o_valid, o_level);
    end
  endtask

  task automatic test_reset;
    i_areset = 1'b1;
    i_sclk = 1'b0; i_mosi = 1'b0; i_cs = 1'b0; i_ready = 1'b0; i_clear = 1'b0;
    repeat (3) tick();
    checks++;
    if ({o_valid, o_overflow, o_desync, o_busy} !== 4'b0000 || o_level !== '0 || o_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v%b ovf%b ds%b busy%b lvl%0d data%h, expected all 0",
               o_valid, o_overflow, o_desync, o_busy, o_level, o_data);
    end
    i_areset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single_word;
    int d0;
    d0 = desync_seen;
    i_ready = 1'b0;
    start_frame();
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_frame: got %b, expected 1", o_busy);
    end
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    end_frame();
    checks++;
    if (o_level !== LW'(1) || o_data !== 8'hA5 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_word: got level %0d data %h busy %b, expected 1 a5 0",
               o_level, o_data, o_busy);
    end
    checks++;
    if (desync_seen != d0) begin
      errors++;
      $display("FAIL single_desync: got %0d pulses, expected 0", desync_seen - d0);
    end
    drain();
  endtask

  task automatic test_back_to_back;
    int d0;
    d0 = desync_seen;
    i_ready = 1'b1;
    start_frame();
    send_word(8'h01, 1'b1, 1'b0, 1'b0);
    send_word(8'h80, 1'b1, 1'b0, 1'b0);
    send_word(8'hFF, 1'b1, 1'b0, 1'b0);
    end_frame();
    checks++;
    if (desync_seen != d0) begin
      errors++;
      $display("FAIL b2b_desync: got %0d pulses, expected 0", desync_seen - d0);
    end
    drain();
  endtask

  task automatic test_overflow;
    i_ready = 1'b0;
    start_frame();
    send_word(8'h11, 1'b1, 1'b0, 1'b0);
    send_word(8'h22, 1'b1, 1'b0, 1'b0);
    send_word(8'h33, 1'b1, 1'b0, 1'b0);
    send_word(8'h44, 1'b1, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    end_frame();
    checks++;
    if (o_level !== LW'(DEPTH) || o_overflow !== 1'b1 || o_data !== 8'h11) begin
      errors++;
      $display("FAIL overflow: got level %0d ovf %b head %h, expected 4 1 11",
               o_level, o_overflow, o_data);
    end
`ifdef SPI_RX_OVF_CNT_EN
    checks++;
    if (o_ovf_count !== 8'd1) begin
      errors++;
      $display("FAIL ovf_count: got %0d, expected 1", o_ovf_count);
    end
`endif
    drain();
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b, expected 1", o_overflow);
    end
  endtask

  task automatic test_clear;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b, expected 0", o_overflow);
    end
`ifdef SPI_RX_OVF_CNT_EN
    checks++;
    if (o_ovf_count !== 8'd0) begin
      errors++;
      $display("FAIL ovf_count_clear: got %0d, expected 0", o_ovf_count);
    end
`endif
  endtask

  task automatic test_full_pop_write;
    i_ready = 1'b0;
    start_frame();
    send_word(8'h61, 1'b1, 1'b0, 1'b0);
    send_word(8'h62, 1'b1, 1'b0, 1'b0);
    send_word(8'h63, 1'b1, 1'b0, 1'b0);
    send_word(8'h64, 1'b1, 1'b0, 1'b0);
    send_word(8'h65, 1'b1, 1'b0, 1'b1);
    end_frame();
    checks++;
    if (o_overflow !== 1'b0 || o_level !== LW'(DEPTH) || o_data !== 8'h62) begin
      errors++;
      $display("FAIL full_pop_after: got ovf %b level %0d head %h, expected 0 4 62",
               o_overflow, o_level, o_data);
    end
    drain();
  endtask

  task automatic test_desync;
    int d0;
    logic [4:0] part;
    d0 = desync_seen;
    part = 5'b10110;
    i_ready = 1'b0;
    start_frame();
    for (int i = 4; i >= 0; i--) send_bit(part[i], 1'b0, 1'b0, 1'b0);
    i_sclk = 1'b0;
    repeat (HALF) tick();
    i_cs = 1'b0;
    repeat (8) tick();
    checks++;
    if (desync_seen != d0 + 1 || o_level !== '0) begin
      errors++;
      $display("FAIL desync_pulse: got %0d pulses level %0d, expected 1 pulse level 0",
               desync_seen - d0, o_level);
    end
    start_frame();
    send_word(8'h3C, 1'b1, 1'b1, 1'b0);
    end_frame();
    checks++;
    if (desync_seen != d0 + 1) begin
      errors++;
      $display("FAIL desync_recover: got %0d pulses, expected 1", desync_seen - d0);
    end
    drain();
  endtask

  task automatic test_reset_midword;
    int d0;
    logic [3:0] part;
    d0 = desync_seen;
    part = 4'b1101;
    i_ready = 1'b0;
    start_frame();
    for (int i = 3; i >= 0; i--) send_bit(part[i], 1'b0, 1'b0, 1'b0);
    i_areset = 1'b1;
    tick();
    checks++;
    if ({o_valid, o_overflow, o_desync, o_busy} !== 4'b0000 || o_level !== '0 || o_data !== '0) begin
      errors++;
      $display("FAIL midword_reset: got v%b ovf%b ds%b busy%b lvl%0d data%h, expected all 0",
               o_valid, o_overflow, o_desync, o_busy, o_level, o_data);
    end
    i_cs = 1'b0;
    i_sclk = 1'b0;
    repeat (2) tick();
    i_areset = 1'b0;
    repeat (8) tick();
    checks++;
    if (desync_seen != d0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL midword_after: got %0d desync pulses busy %b valid %b, expected 0 0 0",
               desync_seen - d0, o_busy, o_valid);
    end
    start_frame();
    send_word(8'h5A, 1'b1, 1'b1, 1'b0);
    end_frame();
    drain();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_full_pop_write();
    test_desync();
    test_reset_midword();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
